ltpi_data_channel_controller_mm: RTL and testbench

LTPI_DATA_CHANNEL_CONTROLLER_MM -- requirements
Module: ltpi_data_channel_controller_mm

---
 rtl/ltpi_data_channel_controller_mm_if.sv | 48 ++++
 rtl/ltpi_data_channel_controller_mm.sv | 96 +++++++++
 tb/tb_ltpi_data_channel_controller_mm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ltpi_data_channel_controller_mm_if.sv
// ltpi_data_channel_controller_mm_if: shared LTPI data-channel types and the Avalon-MM slave bundle
package ltpi_dc_pkg;
  localparam int TIMER_1MS_60MHZ = 60000;
  typedef enum logic [3:0] {
    READ_REQ   = 4'd0,
    WRITE_REQ  = 4'd1,
    READ_COMP  = 4'd2,
    WRITE_COMP = 4'd3,
    CRC_ERROR  = 4'd4
  } data_chnl_cmd_t;
  typedef enum logic [3:0] {
    link_cdr_st,
    link_speed_st,
    link_cfg_st,
    link_accept_st,
    operational_st,
    link_fault_st
  } link_state_t;
  typedef struct packed {
    logic [7:0]     tag;
    data_chnl_cmd_t command;
    logic [31:0]    address;
    logic [3:0]     operation_status;
    logic [3:0]     byte_en;
    logic [31:0]    data;
  } Data_channel_payload_t;
endpackage

interface ltpi_data_channel_controller_mm_if;
  logic [31:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_writeresponsevalid;
  logic [1:0]  avs_response;
  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeresponsevalid, avs_response
  );
  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_writeresponsevalid, avs_response
  );
endinterface

// File: rtl/ltpi_data_channel_controller_mm.sv
// ltpi_data_channel_controller_mm: bridges one Avalon-MM command at a time onto the LTPI data channel
module ltpi_data_channel_controller_mm
  import ltpi_dc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMER_1MS_60MHZ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_channel_rst,
  ltpi_data_channel_controller_mm_if.slave mm,
  output Data_channel_payload_t req,
  output logic                  req_valid,
  input  logic                  req_ack,
  input  Data_channel_payload_t payload_i,
  input  logic                  payload_i_valid,
  input  logic                  frm_crc_error,
  input  link_state_t           local_link_state
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, COMPLETE} state_t;

  state_t      state;
  logic [7:0]  tag;
  logic [31:0] cnt;
  logic        op_wr;
  logic        arst, link_up, start, cmd_ok, hit, fin;
  logic [1:0]  fin_resp;
  logic [31:0] fin_data;

  function automatic logic [31:0] expand(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  assign arst     = reset | data_channel_rst;
  assign link_up  = local_link_state == operational_st;
  assign mm.avs_waitrequest = !(state == IDLE && link_up);
  assign start    = state == IDLE && link_up && (mm.avs_write || mm.avs_read);
  assign cmd_ok   = payload_i.command == CRC_ERROR ||
                    payload_i.command == (op_wr ? WRITE_COMP : READ_COMP);
  assign hit      = payload_i_valid && !frm_crc_error && payload_i.tag == tag && cmd_ok;
  // A link drop outranks a same-cycle response; a response outranks the timeout
  assign fin      = (state == SEND && !link_up) ||
                    (state == WAIT_RESP && (!link_up || hit || cnt == 32'(TIMEOUT_CYCLES - 1)));
  assign fin_resp = (!link_up || !hit) ? 2'b11 :
                    (payload_i.command == CRC_ERROR || payload_i.operation_status != '0) ? 2'b10 : 2'b00;
  assign fin_data = fin_resp == 2'b00 ? payload_i.data & expand(req.byte_en) : '0;

  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state                     <= IDLE;
      req                       <= '0;
      req_valid                 <= 1'b0;
      tag                       <= '0;
      cnt                       <= '0;
      op_wr                     <= 1'b0;
      mm.avs_readdatavalid      <= 1'b0;
      mm.avs_writeresponsevalid <= 1'b0;
      mm.avs_response           <= '0;
      mm.avs_readdata           <= '0;
    end else begin
      mm.avs_readdatavalid      <= 1'b0;
      mm.avs_writeresponsevalid <= 1'b0;
      if (fin) begin
        state                     <= COMPLETE;
        req_valid                 <= 1'b0;
        mm.avs_readdatavalid      <= !op_wr;
        mm.avs_writeresponsevalid <= op_wr;
        mm.avs_response           <= fin_resp;
        mm.avs_readdata           <= fin_data;
      end else
        case (state)
          IDLE:
            if (start) begin
              op_wr                <= mm.avs_write;
              req.tag              <= tag;
              req.command          <= mm.avs_write ? WRITE_REQ : READ_REQ;
              req.address          <= mm.avs_address;
              req.operation_status <= '0;
              req.byte_en          <= mm.avs_byteenable;
              req.data             <= mm.avs_write ? mm.avs_writedata & expand(mm.avs_byteenable) : '0;
              req_valid            <= 1'b1;
              state                <= SEND;
            end
          SEND:
            if (req_ack) begin
              req_valid <= 1'b0;
              cnt       <= '0;
              state     <= WAIT_RESP;
            end
          WAIT_RESP: cnt <= cnt + 32'd1;
          COMPLETE: begin
            tag   <= tag + 8'd1;
            state <= IDLE;
          end
        endcase
    end
endmodule

// File: tb/tb_ltpi_data_channel_controller_mm.sv
// tb_ltpi_data_channel_controller_mm: directed vector table plus hand-written corner sequences
module tb_ltpi_data_channel_controller_mm;
  import ltpi_dc_pkg::*;
  localparam int TO = 20;

  logic clk = 1'b0, reset = 1'b1, data_channel_rst = 1'b0;
  Data_channel_payload_t req, payload_i;
  logic req_valid, req_ack = 1'b0, payload_i_valid = 1'b0, frm_crc_error = 1'b0;
  link_state_t local_link_state = operational_st;
  ltpi_data_channel_controller_mm_if mm();

  ltpi_data_channel_controller_mm #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .data_channel_rst(data_channel_rst), .mm(mm),
    .req(req), .req_valid(req_valid), .req_ack(req_ack),
    .payload_i(payload_i), .payload_i_valid(payload_i_valid), .frm_crc_error(frm_crc_error),
    .local_link_state(local_link_state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_pulse = 0;
  logic [7:0] exp_tag = 8'd0;

  always @(negedge clk) begin
    if (mm.avs_readdatavalid) n_pulse++;
    if (mm.avs_writeresponsevalid) n_pulse++;
  end

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int ack_dly;
    data_chnl_cmd_t rcmd; logic [3:0] rst_st; logic [31:0] rdata;
    logic [31:0] exp_req_data; logic [1:0] exp_resp; logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[7];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int n = 0;
    while (mm.avs_waitrequest && n < 50) begin step(); n++; end
    chk("wait_idle", 32'(mm.avs_waitrequest), 0);
    mm.avs_write = wr; mm.avs_read = rd; mm.avs_address = addr;
    mm.avs_writedata = wdata; mm.avs_byteenable = be;
    step();
    mm.avs_write = 1'b0; mm.avs_read = 1'b0;
    chk("req_valid_up", 32'(req_valid), 1);
  endtask

  task automatic ack(input int dly);
    repeat (dly) step();
    chk("req_hold", 32'(req_valid), 1);
    req_ack = 1'b1; step(); req_ack = 1'b0;
    chk("req_drop", 32'(req_valid), 0);
  endtask

  task automatic send(input logic [7:0] t, input data_chnl_cmd_t c, input logic [3:0] st,
                      input logic [31:0] d, input logic crc);
    payload_i = '0;
    payload_i.tag = t; payload_i.command = c; payload_i.operation_status = st; payload_i.data = d;
    payload_i_valid = 1'b1; frm_crc_error = crc;
    step();
    payload_i_valid = 1'b0; frm_crc_error = 1'b0;
  endtask

  task automatic expect_done(input string nm, input logic wr, input logic [1:0] resp, input logic [31:0] rdata);
    chk({nm, "_pulse"}, 32'({mm.avs_readdatavalid, mm.avs_writeresponsevalid}), wr ? 32'd1 : 32'd2);
    chk({nm, "_resp"}, 32'(mm.avs_response), 32'(resp));
    if (!wr) chk({nm, "_rdata"}, mm.avs_readdata, rdata);
    step();
    chk({nm, "_pulse_end"}, 32'({mm.avs_readdatavalid, mm.avs_writeresponsevalid}), 0);
    exp_tag = exp_tag + 8'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    vecs[0] = '{1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 3, WRITE_COMP, 4'd0, 32'h0, 32'h00BB00DD, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h08, 32'h0,        4'b1111, 0, READ_COMP,  4'd0, 32'h12345678, 32'h0, 2'b00, 32'h12345678};
    vecs[2] = '{1'b0, 32'h0C, 32'h0,        4'b0011, 1, READ_COMP,  4'd0, 32'hCAFEBABE, 32'h0, 2'b00, 32'h0000BABE};
    vecs[3] = '{1'b0, 32'h14, 32'h0,        4'b1111, 2, READ_COMP,  4'd1, 32'hFFFFFFFF, 32'h0, 2'b10, 32'h0};
    vecs[4] = '{1'b1, 32'h18, 32'h01020304, 4'b1111, 0, WRITE_COMP, 4'd2, 32'h0, 32'h01020304, 2'b10, 32'h0};
    vecs[5] = '{1'b0, 32'h1C, 32'h0,        4'b1111, 1, CRC_ERROR,  4'd0, 32'h87654321, 32'h0, 2'b10, 32'h0};
    vecs[6] = '{1'b1, 32'h24, 32'h11223344, 4'b1000, 0, WRITE_COMP, 4'd0, 32'h0, 32'h11000000, 2'b00, 32'h0};
    mm.avs_read = 1'b0; mm.avs_write = 1'b0; mm.avs_address = '0;
    mm.avs_writedata = '0; mm.avs_byteenable = '0; payload_i = '0;
    step(); step();
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_req_tag", 32'(req.tag), 0);
    chk("rst_req_cmd", 32'(req.command), 32'(READ_REQ));
    chk("rst_req_addr", req.address, 0);
    chk("rst_req_data", req.data, 0);
    chk("rst_pulses", 32'({mm.avs_readdatavalid, mm.avs_writeresponsevalid}), 0);
    chk("rst_resp", 32'(mm.avs_response), 0);
    chk("rst_rdata", mm.avs_readdata, 0);
    reset = 1'b0;
    step();
    chk("idle_waitreq", 32'(mm.avs_waitrequest), 0);

    foreach (vecs[i]) begin
      base = n_pulse;
      issue(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      chk("req_tag", 32'(req.tag), 32'(exp_tag));
      chk("req_cmd", 32'(req.command), vecs[i].wr ? 32'(WRITE_REQ) : 32'(READ_REQ));
      chk("req_addr", req.address, vecs[i].addr);
      chk("req_data", req.data, vecs[i].exp_req_data);
      ack(vecs[i].ack_dly);
      chk("req_data_stable", req.data, vecs[i].exp_req_data);
      send(exp_tag, vecs[i].rcmd, vecs[i].rst_st, vecs[i].rdata, 1'b0);
      expect_done("vec", vecs[i].wr, vecs[i].exp_resp, vecs[i].exp_rdata);
      chk("vec_pulse_count", 32'(n_pulse - base), 1);
    end

    // frames with wrong tag, CRC error or wrong command are ignored
    issue(1'b0, 1'b1, 32'h40, 32'h0, 4'hF);
    ack(1);
    send(exp_tag + 8'd1, READ_COMP, 4'd0, 32'hDEAD0001, 1'b0);
    chk("wrong_tag_ignored", 32'({mm.avs_readdatavalid, mm.avs_writeresponsevalid}), 0);
    send(exp_tag, READ_COMP, 4'd0, 32'hDEAD0002, 1'b1);
    chk("crc_err_ignored", 32'({mm.avs_readdatavalid, mm.avs_writeresponsevalid}), 0);
    send(exp_tag, WRITE_COMP, 4'd0, 32'hDEAD0003, 1'b0);
    chk("wrong_cmd_ignored", 32'({mm.avs_readdatavalid, mm.avs_writeresponsevalid}), 0);
    send(exp_tag, READ_COMP, 4'd0, 32'h0BADF00D, 1'b0);
    expect_done("filter", 1'b0, 2'b00, 32'h0BADF00D);

    // timeout lands exactly TO cycles after entering WAIT_RESP
    issue(1'b0, 1'b1, 32'h44, 32'h0, 4'hF);
    req_ack = 1'b1; step(); req_ack = 1'b0;
    n = 0;
    while (!mm.avs_readdatavalid && n < 100) begin step(); n++; end
    chk("timeout_cycles", 32'(n), TO);
    expect_done("timeout", 1'b0, 2'b11, 32'h0);

    // link drop in WAIT_RESP completes at once and blocks new commands
    issue(1'b0, 1'b1, 32'h48, 32'h0, 4'hF);
    ack(0);
    step(); step();
    local_link_state = link_fault_st;
    step();
    expect_done("link_drop", 1'b0, 2'b11, 32'h0);
    base = n_pulse;
    mm.avs_read = 1'b1;
    repeat (3) step();
    chk("link_down_waitreq", 32'(mm.avs_waitrequest), 1);
    chk("link_down_no_req", 32'(req_valid), 0);
    mm.avs_read = 1'b0;
    chk("link_down_no_pulse", 32'(n_pulse - base), 0);
    local_link_state = operational_st;
    #1;
    chk("link_up_waitreq", 32'(mm.avs_waitrequest), 0);

    // read and write together issue the write
    issue(1'b1, 1'b1, 32'h20, 32'h55667788, 4'hF);
    chk("rw_cmd", 32'(req.command), 32'(WRITE_REQ));
    chk("rw_data", req.data, 32'h55667788);
    ack(0);
    send(exp_tag, WRITE_COMP, 4'd0, 32'h0, 1'b0);
    expect_done("rw", 1'b1, 2'b00, 32'h0);

    // 260 back-to-back reads across the tag wrap
    base = n_pulse;
    for (int i = 0; i < 260; i++) begin
      issue(1'b0, 1'b1, 32'(i * 4), 32'h0, 4'hF);
      chk("b2b_tag", 32'(req.tag), 32'(exp_tag));
      ack(0);
      send(exp_tag, READ_COMP, 4'd0, 32'(i) ^ 32'hA5A50000, 1'b0);
      expect_done("b2b", 1'b0, 2'b00, 32'(i) ^ 32'hA5A50000);
    end
    chk("b2b_pulse_count", 32'(n_pulse - base), 260);

    // 11 earlier + 260 transactions -> tag 271 mod 256 = 15; then abort with data_channel_rst
    issue(1'b1, 1'b0, 32'h50, 32'hFFFFFFFF, 4'hF);
    chk("tag_after_wrap", 32'(req.tag), 32'd15);
    base = n_pulse;
    data_channel_rst = 1'b1;
    #1;
    chk("chrst_req_valid", 32'(req_valid), 0);
    step();
    data_channel_rst = 1'b0;
    repeat (4) step();
    chk("chrst_no_pulse", 32'(n_pulse - base), 0);
    exp_tag = 8'd0;
    issue(1'b0, 1'b1, 32'h54, 32'h0, 4'b1100);
    chk("chrst_tag", 32'(req.tag), 0);
    ack(0);
    send(exp_tag, READ_COMP, 4'd0, 32'h9ABCDEF0, 1'b0);
    expect_done("chrst_next", 1'b0, 2'b00, 32'h9ABC0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
